// File: rtl/k_rd_prefetch_if.sv
// Read-side prefetch bus: FIFO pop side (rempty/rmem_data/rget) and consumer
// valid/ready side with occupancy and transfer statistics.
interface k_rd_prefetch_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rmem_data;
    logic                  rget;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;
    logic [1:0]            rlevel;
    logic [CNT_WIDTH-1:0]  rxfer_cnt;

    // slave: the prefetch stage itself
    modport slave (
        input  rempty, rmem_data, rready,
        output rget, rdata, rvalid, rlevel, rxfer_cnt
    );

    // master: FIFO read control plus consumer environment
    modport master (
        output rempty, rmem_data, rready,
        input  rget, rdata, rvalid, rlevel, rxfer_cnt
    );
endinterface

// File: rtl/k_rd_prefetch.sv
// Async FIFO read-side output stage: 2-entry prefetch (head + skid) giving a
// registered valid/ready interface with zero-bubble throughput.
module k_rd_prefetch #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    k_rd_prefetch_if.slave         bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_rget;
    logic                  w_rvalid;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = w_rget;
    assign w_pop  = w_rvalid & bus.rready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) r_state <= ST_EMPTY;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_pop && !w_push) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Reset gates rget so the read control sees no pop while the stage is held.
    always_comb begin
        w_rget   = 1'b0;
        w_rvalid = 1'b0;
        if (rrst_n) w_rget = ~bus.rempty & ((r_state != ST_FULL) | bus.rready);
        w_rvalid = (r_state != ST_EMPTY);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_head <= '0;
            r_skid <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop) r_cnt <= r_cnt + CNT_WIDTH'(1);
            case (r_state)
                ST_EMPTY: if (w_push) r_head <= bus.rmem_data;
                ST_ONE: begin
                    if (w_push && w_pop) r_head <= bus.rmem_data;
                    else if (w_push)     r_skid <= bus.rmem_data;
                end
                ST_FULL: begin
                    // skid always drains into head first to preserve order
                    if (w_pop)  r_head <= r_skid;
                    if (w_push) r_skid <= bus.rmem_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.rget      = w_rget;
    assign bus.rvalid    = w_rvalid;
    assign bus.rdata     = r_head;
    assign bus.rlevel    = r_state;
    assign bus.rxfer_cnt = r_cnt;
endmodule

// File: tb/tb_k_rd_prefetch.sv
// Directed bench for k_rd_prefetch: a queue stands in for the FIFO memory,
// expected values are hand-computed per step.
module tb_k_rd_prefetch;
    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   ngets = 0;
    logic [7:0] q[$];

    always #5 rclk = ~rclk;

    k_rd_prefetch_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
    k_rd_prefetch_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

    k_rd_prefetch #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .rclk(rclk), .rrst_n(rrst_n), .bus(bus)
    );
    // narrow-counter copy sees the same stimulus, used for the wrap check
    k_rd_prefetch #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .bus(bus4)
    );
    assign bus4.rempty    = bus.rempty;
    assign bus4.rmem_data = bus.rmem_data;
    assign bus4.rready    = bus.rready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        bus.rempty    = (q.size() == 0);
        bus.rmem_data = (q.size() != 0) ? q[0] : 8'hEE;
    endtask

    // one clock: apply rready, sample rget, pop model FIFO on the edge
    task automatic cyc(input logic rdy);
        logic g;
        bus.rready = rdy;
        refresh();
        #1;
        g = bus.rget;
        @(posedge rclk);
        if (g && q.size() != 0) begin
            void'(q.pop_front());
            ngets++;
        end
        #1;
        refresh();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] lvl, input logic [7:0] d);
        chk({tag, "_vld"}, {31'd0, bus.rvalid}, {31'd0, v});
        chk({tag, "_lvl"}, {30'd0, bus.rlevel}, {30'd0, lvl});
        if (v) chk({tag, "_dat"}, {24'd0, bus.rdata}, {24'd0, d});
    endtask

    initial begin
        int g0;
        // reset with traffic pending: nothing may leave
        bus.rready = 1'b1;
        q.push_back(8'h11);
        refresh();
        #2;
        chk("rst_rget", {31'd0, bus.rget}, 32'd0);
        chk("rst_vld", {31'd0, bus.rvalid}, 32'd0);
        chk("rst_lvl", {30'd0, bus.rlevel}, 32'd0);
        chk("rst_cnt", {16'd0, bus.rxfer_cnt}, 32'd0);
        chk("rst_dat", {24'd0, bus.rdata}, 32'd0);
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_q", q.size(), 32'd1);
        rrst_n = 1'b1;
        #1;
        chk("first_rget", {31'd0, bus.rget}, 32'd1);
        cyc(1'b1);
        chk_out("first", 1'b1, 2'd1, 8'h11);
        #1;
        chk("emp_rget", {31'd0, bus.rget}, 32'd0);
        cyc(1'b1);
        chk_out("emp", 1'b0, 2'd0, 8'h00);
        chk("emp_cnt", {16'd0, bus.rxfer_cnt}, 32'd1);

        // streaming 0x01..0x10 with rready held high
        for (int i = 1; i <= 16; i++) q.push_back(8'(i));
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1);
            chk_out("strm", 1'b1, 2'd1, 8'(i));
        end
        cyc(1'b1);
        chk_out("strm_end", 1'b0, 2'd0, 8'h00);
        chk("strm_cnt", {16'd0, bus.rxfer_cnt}, 32'd17);
        chk("wrap_cnt4", {28'd0, bus4.rxfer_cnt}, 32'd1);

        // back-pressure: two pushes then stall
        q.push_back(8'hA0); q.push_back(8'hA1); q.push_back(8'hA2);
        g0 = ngets;
        cyc(1'b0);
        chk_out("bp1", 1'b1, 2'd1, 8'hA0);
        cyc(1'b0);
        chk_out("bp2", 1'b1, 2'd2, 8'hA0);
        cyc(1'b0);
        chk_out("bp3", 1'b1, 2'd2, 8'hA0);
        chk("bp_gets", ngets - g0, 32'd2);
        bus.rready = 1'b1;
        #1;
        chk("bp_rget", {31'd0, bus.rget}, 32'd1);
        cyc(1'b1);
        chk_out("bp_d1", 1'b1, 2'd2, 8'hA1);
        cyc(1'b1);
        chk_out("bp_d2", 1'b1, 2'd1, 8'hA2);
        cyc(1'b1);
        chk_out("bp_d3", 1'b0, 2'd0, 8'h00);
        chk("bp_cnt", {16'd0, bus.rxfer_cnt}, 32'd20);

        // simultaneous push/pop in FULL
        q.push_back(8'h30); q.push_back(8'h31); q.push_back(8'h32);
        cyc(1'b0);
        cyc(1'b0);
        chk_out("full0", 1'b1, 2'd2, 8'h30);
        cyc(1'b1);
        chk_out("full1", 1'b1, 2'd2, 8'h31);
        cyc(1'b1);
        chk_out("full2", 1'b1, 2'd1, 8'h32);
        cyc(1'b1);
        chk_out("full3", 1'b0, 2'd0, 8'h00);
        chk("full_cnt", {16'd0, bus.rxfer_cnt}, 32'd23);

        // reset while FULL
        q.push_back(8'h40); q.push_back(8'h41); q.push_back(8'h42);
        cyc(1'b0);
        cyc(1'b0);
        chk_out("mid_pre", 1'b1, 2'd2, 8'h40);
        rrst_n = 1'b0;
        #1;
        chk("mid_rget", {31'd0, bus.rget}, 32'd0);
        chk("mid_vld", {31'd0, bus.rvalid}, 32'd0);
        chk("mid_lvl", {30'd0, bus.rlevel}, 32'd0);
        chk("mid_cnt", {16'd0, bus.rxfer_cnt}, 32'd0);
        chk("mid_dat", {24'd0, bus.rdata}, 32'd0);
        @(posedge rclk);
        #1;
        chk("mid_q", q.size(), 32'd1);
        q.delete();
        q.push_back(8'h55);
        refresh();
        rrst_n = 1'b1;
        cyc(1'b1);
        chk_out("post", 1'b1, 2'd1, 8'h55);
        chk("post_cnt0", {16'd0, bus.rxfer_cnt}, 32'd0);
        cyc(1'b1);
        chk_out("post_end", 1'b0, 2'd0, 8'h00);
        chk("post_cnt", {16'd0, bus.rxfer_cnt}, 32'd1);
        chk("post_cnt4", {28'd0, bus4.rxfer_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/k_rd_prefetch.md
# k_rd_prefetch

Read-side output stage of the async FIFO, directly downstream of the read pointer/empty control in the rclk domain. Watches the FIFO empty flag, issues read pops (rget) and captures memory read data into a 2-entry prefetch buffer. Presents the data to the consumer over a registered valid/ready interface, so the consumer sees zero-bubble throughput and no combinational path from rready to the FIFO pointer logic other than the pop request.

## Interface
- DATA_WIDTH, 8, width of FIFO data word
- CNT_WIDTH, 16, width of transfer statistics counter
- rclk  input  1  read-domain clock; all state updates on rising edge
- rrst_n  input  1  reset, asynchronous, active-low
- rempty  input  1  FIFO empty flag from read control; 1 = no word available
- rmem_data  input  DATA_WIDTH  FIFO memory read data at current raddr; valid combinationally in the same cycle
- rget  output  1  pop request to read control; combinational
- rdata  output  DATA_WIDTH  head-of-buffer data, registered
- rvalid  output  1  rdata holds a valid word, registered
- rready  input  1  consumer accepts rdata this cycle
- rlevel  output  2  buffer occupancy 0..2, registered
- rxfer_cnt  output  CNT_WIDTH  count of completed consumer handshakes, registered

## Operation
- Storage: head register H (drives rdata) and skid register S. Occupancy state machine: EMPTY (0), ONE (1, H valid), FULL (2, H and S valid).
- pop = rvalid & rready; push = rget.
- rget = ~rempty & (state != FULL | rready). Never asserted while rempty = 1.
- Transitions (push, pop):
  - EMPTY: push -> ONE, H <= rmem_data; no push -> EMPTY. pop impossible (rvalid = 0).
  - ONE: push & pop -> ONE, H <= rmem_data; push only -> FULL, S <= rmem_data; pop only -> EMPTY; neither -> ONE.
  - FULL: push & pop -> FULL, H <= S, S <= rmem_data; pop only -> ONE, H <= S; no pop -> FULL, and push cannot occur.
- Ordering: words leave on rdata in exactly the order popped from the FIFO; S is never bypassed.
- rvalid = (state != EMPTY); rlevel = state encoding 0/1/2.
- rdata holds its value while rvalid & ~rready; it changes only on pop or on push into EMPTY.
- rxfer_cnt increments by 1 on every pop; wraps from 2^CNT_WIDTH-1 to 0; no saturation.
- rdata is don't-care while rvalid = 0; H and S are not required to clear on pop.

## Timing
- Reset (rrst_n = 0, asynchronous assert): state EMPTY, rvalid 0, rlevel 0, rxfer_cnt 0, rdata 0. rget is 0 during reset regardless of rempty.
- Reset release is synchronous to rclk; the first push can occur in the first rclk edge after deassertion.
- Latency: rempty falls in cycle N with buffer EMPTY -> rget = 1 in cycle N -> rvalid = 1, rdata = word in cycle N+1.
- Throughput: with rempty = 0 and rready held 1, one word per cycle, rlevel steady at 1.
- Back-pressure: rready = 0 fills the buffer to 2 words in two pushes, then rget = 0. First rready = 1 in FULL allows a push in the same cycle.
- rempty and rready change on the same edge: rget is evaluated on current-cycle values only; no registered lookahead.
- Reset mid-operation: buffered words are discarded, rxfer_cnt is cleared, and no rget pulses during reset. FIFO pointer recovery is the read control's responsibility.

## Test plan
- Reset: drive rempty = 0 and rready = 1 with rrst_n = 0 -> rget = 0, rvalid = 0, rlevel = 0, rxfer_cnt = 0. After release, first word 0x11 appears on rdata one cycle after the first rget.
- Streaming: FIFO supplies 0x01..0x10 back-to-back with rready = 1 -> 16 consecutive rvalid cycles, data in order, rlevel = 1 throughout, rxfer_cnt = 16.
- Back-pressure: words 0xA0, 0xA1, 0xA2 available and rready = 0 -> exactly 2 rget pulses, rlevel = 2, rdata = 0xA0 held. Then rready = 1 for 3 cycles -> rdata 0xA0, 0xA1, 0xA2, and the third rget fires in the first rready cycle.
- Simultaneous push/pop in FULL: buffer holds 0x30/0x31, next word 0x32, rready = 1 -> rlevel stays 2 and next rdata = 0x31. Empty-side check: rempty = 1 with rlevel = 1 and rready = 1 -> rget = 0, rlevel goes to 0, rvalid = 0.
- Counter wrap with CNT_WIDTH = 4: 17 handshakes -> rxfer_cnt reads 1.
- Mid-stream reset: assert rrst_n = 0 while rlevel = 2 -> all outputs return to reset values immediately, and no stale word is presented after release.
